// File: rtl/serial_matmul_cmdq.sv
// serial_matmul_cmdq: command FIFO between the processor and serial_matmul, dropping foreign opcodes.
// Optional build macro SERIAL_MATMUL_CMDQ_BYPASS_EN: empty-queue commands flow straight through to deq_*.
module serial_matmul_cmdq #(
  parameter int         DEPTH    = 4,
  parameter logic [6:0] OPCODE   = 7'h0B,
  parameter int         CNT_BITS = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [63:0]                cmd_rs1_i,
  input  logic [6:0]                 cmd_inst_funct_i,
  input  logic [6:0]                 cmd_inst_opcode_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output logic [63:0]                deq_rs1_o,
  output logic [6:0]                 deq_funct_o,
  output logic [6:0]                 deq_opcode_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_BITS-1:0]        drop_cnt_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entries hold {funct, rs1}; the opcode is implied since only OPCODE is ever stored.
  logic [70:0]         mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [CNT_BITS-1:0] drop_q, drop_d;
  logic [70:0]         head;
  logic                match, enq_fire, empty, byp_valid, byp_fire, wr_en, rd_en;

  assign head        = mem_q[rd_ptr_q];
  assign cmd_ready_o = count_q != CW'(DEPTH);
  assign count_o     = count_q;
  assign drop_cnt_o  = drop_q;

  // Handshake decode, dequeue view (queue head or bypass) and next-state computation.
  always_comb begin
    match     = cmd_inst_opcode_i == OPCODE;
    enq_fire  = cmd_valid_i & cmd_ready_o;
    empty     = count_q == '0;
`ifdef SERIAL_MATMUL_CMDQ_BYPASS_EN
    byp_valid = empty & cmd_valid_i & match;
`else
    byp_valid = 1'b0;
`endif
    deq_valid_o  = !empty | byp_valid;
    deq_rs1_o    = !empty ? head[63:0] : byp_valid ? cmd_rs1_i : 64'd0;
    deq_funct_o  = !empty ? head[70:64] : byp_valid ? cmd_inst_funct_i : 7'd0;
    deq_opcode_o = deq_valid_o ? OPCODE : 7'd0;
    byp_fire  = byp_valid & deq_ready_i;
    wr_en     = enq_fire & match & !byp_fire;
    rd_en     = !empty & deq_ready_i;
    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(wr_en) - CW'(rd_en);
    drop_d    = (enq_fire & !match & (drop_q != '1)) ? drop_q + CNT_BITS'(1) : drop_q;
  end

  // Control state; async active-low reset discards everything in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  // Storage array, deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {cmd_inst_funct_i, cmd_rs1_i};
  end
endmodule

// File: tb/tb_serial_matmul_cmdq.sv
// tb_serial_matmul_cmdq: directed self-checking bench for serial_matmul_cmdq.
module tb_serial_matmul_cmdq;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid_i, deq_ready_i;
  logic        cmd_ready_o, deq_valid_o;
  logic [63:0] cmd_rs1_i, deq_rs1_o;
  logic [6:0]  cmd_inst_funct_i, cmd_inst_opcode_i, deq_funct_o, deq_opcode_o;
  logic [2:0]  count_o;
  logic [7:0]  drop_cnt_o;
  int total = 0;
  int bad = 0;

  serial_matmul_cmdq dut (
    .clk(clk), .reset(reset),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_rs1_i(cmd_rs1_i), .cmd_inst_funct_i(cmd_inst_funct_i), .cmd_inst_opcode_i(cmd_inst_opcode_i),
    .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready_i),
    .deq_rs1_o(deq_rs1_o), .deq_funct_o(deq_funct_o), .deq_opcode_o(deq_opcode_o),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] rs1, input logic [6:0] fn, input logic [6:0] op, input logic rdy);
    cmd_valid_i = v;
    cmd_rs1_i = rs1;
    cmd_inst_funct_i = fn;
    cmd_inst_opcode_i = op;
    deq_ready_i = rdy;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 7'h0B, 0);
    repeat (2) step();
    chk("rst_count", count_o, 0);
    chk("rst_ready", cmd_ready_o, 1);
    chk("rst_valid", deq_valid_o, 0);
    chk("rst_drop", drop_cnt_o, 0);
    chk("rst_rs1", deq_rs1_o, 0);
    reset = 1'b1;
    step();
    // fill to full with deq stalled
    for (int i = 1; i <= 4; i++) begin
      drive(1, 64'h11 * i, 7'(i), 7'h0B, 0);
      step();
    end
    drive(0, 0, 0, 7'h0B, 0);
    chk("full_count", count_o, 4);
    chk("full_ready", cmd_ready_o, 0);
    chk("full_valid", deq_valid_o, 1);
    chk("full_opcode", deq_opcode_o, 7'h0B);
    step();
    chk("stall_rs1", deq_rs1_o, 64'h11);
    chk("stall_funct", deq_funct_o, 1);
    // full + enq attempt + deq in the same cycle
    drive(1, 64'h55, 0, 7'h0B, 1);
    chk("full_deq_ready", cmd_ready_o, 0);
    chk("order0", deq_rs1_o, 64'h11);
    step();
    drive(0, 0, 0, 7'h0B, 1);
    chk("ready_back", cmd_ready_o, 1);
    chk("after_full_count", count_o, 3);
    for (int i = 2; i <= 4; i++) begin
      chk("order", deq_rs1_o, 64'h11 * i);
      chk("order_funct", deq_funct_o, 7'(i));
      step();
    end
    chk("drain_count", count_o, 0);
    chk("drain_valid", deq_valid_o, 0);
    // foreign opcode drop
    drive(1, 5, 0, 7'h2B, 0);
    chk("drop_ready", cmd_ready_o, 1);
    step();
    drive(0, 0, 0, 7'h0B, 0);
    chk("drop_count", count_o, 0);
    chk("drop_cnt1", drop_cnt_o, 1);
    chk("drop_valid", deq_valid_o, 0);
    drive(1, 5, 0, 7'h2B, 0);
    repeat (99) step();
    chk("drop_cnt100", drop_cnt_o, 100);
    repeat (200) step();
    chk("drop_sat", drop_cnt_o, 8'hFF);
    // drops interleaved with stored commands keep order
    drive(1, 64'hA, 0, 7'h0B, 0); step();
    drive(1, 64'hB, 0, 7'h2B, 0); step();
    drive(1, 64'hC, 0, 7'h0B, 0); step();
    drive(0, 0, 0, 7'h0B, 1);
    chk("mix_count", count_o, 2);
    chk("mix_first", deq_rs1_o, 64'hA);
    step();
    chk("mix_second", deq_rs1_o, 64'hC);
    step();
    chk("mix_empty", count_o, 0);
    // async reset mid-stream with three entries
    for (int i = 0; i < 3; i++) begin
      drive(1, 64'(i), 0, 7'h0B, 0);
      step();
    end
    drive(0, 0, 0, 7'h0B, 0);
    chk("pre_rst_count", count_o, 3);
    reset = 1'b0;
    #1;
    chk("async_rst_count", count_o, 0);
    reset = 1'b1;
    step();
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", deq_valid_o, 0);
    chk("mid_rst_ready", cmd_ready_o, 1);
    chk("mid_rst_drop", drop_cnt_o, 0);
    // steady enq+deq at occupancy 2, wraps pointers several times
    drive(1, 0, 0, 7'h0B, 0); step();
    drive(1, 1, 0, 7'h0B, 0); step();
    for (int i = 0; i < 20; i++) begin
      drive(1, 64'(i + 2), 0, 7'h0B, 1);
      chk("steady_rs1", deq_rs1_o, 64'(i));
      chk("steady_count", count_o, 2);
      step();
    end
    drive(0, 0, 0, 7'h0B, 1);
    chk("steady_tail", deq_rs1_o, 20);
    step(); step();
    chk("steady_empty", count_o, 0);
    // empty-queue latency, with and without bypass
    drive(1, 64'hAB, 3, 7'h0B, 1);
`ifdef SERIAL_MATMUL_CMDQ_BYPASS_EN
    chk("byp_valid", deq_valid_o, 1);
    chk("byp_rs1", deq_rs1_o, 64'hAB);
    chk("byp_funct", deq_funct_o, 3);
    step();
    drive(0, 0, 0, 7'h0B, 1);
    chk("byp_count", count_o, 0);
    chk("byp_after_valid", deq_valid_o, 0);
`else
    chk("nobyp_valid0", deq_valid_o, 0);
    step();
    drive(0, 0, 0, 7'h0B, 1);
    chk("nobyp_valid1", deq_valid_o, 1);
    chk("nobyp_rs1", deq_rs1_o, 64'hAB);
    chk("nobyp_funct", deq_funct_o, 3);
    chk("nobyp_count", count_o, 1);
    step();
    chk("nobyp_count_after", count_o, 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
